// File: rtl/stage3_mem_access_if.sv
// Bundle of EX/MEM entry fields, data-bus signals and writeback results for the memory-access unit.
// master = pipeline/bus environment side, slave = the memory-access unit.
interface stage3_mem_access_if;
  logic        valid_m;
  logic        dren_m;
  logic        dwen_m;
  logic        reg_write_m;
  logic [4:0]  rd_m;
  logic [2:0]  w_sel_m;
  logic [2:0]  load_type_m;
  logic [31:0] port_out_m;
  logic [31:0] rs2_data_m;
  logic [31:0] pc4_m;
  logic [31:0] imm_U_m;
  logic [31:0] csr_rdata;
  logic        advance;
  logic        flush;

  logic        dbus_ren;
  logic        dbus_wen;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byte_en;
  logic [31:0] dbus_rdata;
  logic        dbus_busy;

  logic        mem_busy;
  logic [31:0] reg_wdata;
  logic [4:0]  rd_w;
  logic        reg_write;
  logic        mal_load;
  logic        mal_store;
  logic        bus_fault;

  modport master (
    output valid_m, dren_m, dwen_m, reg_write_m, rd_m, w_sel_m, load_type_m,
           port_out_m, rs2_data_m, pc4_m, imm_U_m, csr_rdata, advance, flush,
           dbus_rdata, dbus_busy,
    input  dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
           mem_busy, reg_wdata, rd_w, reg_write, mal_load, mal_store, bus_fault
  );

  modport slave (
    input  valid_m, dren_m, dwen_m, reg_write_m, rd_m, w_sel_m, load_type_m,
           port_out_m, rs2_data_m, pc4_m, imm_U_m, csr_rdata, advance, flush,
           dbus_rdata, dbus_busy,
    output dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
           mem_busy, reg_wdata, rd_w, reg_write, mal_load, mal_store, bus_fault
  );
endinterface

// File: rtl/stage3_mem_access_unit.sv
// Memory stage of the 3-stage pipeline: issues data-bus loads/stores, aligns load data,
// selects the writeback value and stalls the pipeline while an access is outstanding.
module stage3_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 nRST,
  stage3_mem_access_if.slave   io_mau
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_byte_en;
  logic              r_ren;
  logic              r_wen;
  logic              r_fault;
  logic              r_flushed;

  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_is_mem;
  logic        w_mal;
  logic        w_mem_op;
  logic [3:0]  w_be_c;
  logic [31:0] w_st_wdata;
  logic        w_timeout;
  logic        w_req;
  logic        w_ren;
  logic        w_wen;
  logic        w_mem_busy;
  logic        w_drain;
  logic        w_fault;
  logic [31:0] w_rdata_src;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_wb_data;

  assign w_off    = io_mau.port_out_m[1:0];
  assign w_size   = io_mau.load_type_m[1:0];
  assign w_is_mem = io_mau.dren_m | io_mau.dwen_m;
  assign w_mal    = w_is_mem & (((w_size == 2'b01) & w_off[0]) |
                                ((w_size == 2'b10) & (w_off != 2'b00)));
  assign w_mem_op = io_mau.valid_m & w_is_mem & ~w_mal;

  // Lane enables and lane-replicated store data for the current entry
  always_comb begin
    w_be_c     = 4'b0000;
    w_st_wdata = io_mau.rs2_data_m;
    case (w_size)
      2'b00: begin
        w_be_c     = 4'b0001 << w_off;
        w_st_wdata = {4{io_mau.rs2_data_m[7:0]}};
      end
      2'b01: begin
        w_be_c     = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{io_mau.rs2_data_m[15:0]}};
      end
      2'b10:   w_be_c = 4'b1111;
      default: w_be_c = 4'b0000;
    endcase
  end

  assign w_timeout = (r_state == BUSY) && (TIMEOUT_CYCLES != 0) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Request is held for the whole BUSY phase, even after a flush, until the bus finishes
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      IDLE:    w_req = w_mem_op;
      BUSY:    w_req = ~w_timeout;
      default: w_req = 1'b0;
    endcase
    w_req = w_req & nRST;
  end

  assign w_ren      = w_req & ((r_state == IDLE) ? io_mau.dren_m : r_ren);
  assign w_wen      = w_req & ((r_state == IDLE) ? io_mau.dwen_m : r_wen);
  assign w_mem_busy = w_req & io_mau.dbus_busy;
  assign w_drain    = (r_state == BUSY) & r_flushed;
  assign w_fault    = ((r_state == HOLD) & r_fault) | w_timeout;

  assign w_rdata_src = (r_state == HOLD) ? r_rdata : io_mau.dbus_rdata;
  assign w_lane      = w_rdata_src >> {w_off, 3'b000};

  always_comb begin
    w_load_val = w_lane;
    case (io_mau.load_type_m)
      3'b000:  w_load_val = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_val = {24'd0, w_lane[7:0]};
      3'b101:  w_load_val = {16'd0, w_lane[15:0]};
      default: w_load_val = w_lane;
    endcase
  end

  always_comb begin
    w_wb_data = 32'd0;
    case (io_mau.w_sel_m)
      3'd0:    w_wb_data = w_load_val;
      3'd1:    w_wb_data = io_mau.pc4_m;
      3'd2:    w_wb_data = io_mau.imm_U_m;
      3'd3:    w_wb_data = io_mau.port_out_m;
      3'd4:    w_wb_data = io_mau.csr_rdata;
      default: w_wb_data = 32'd0;
    endcase
  end

  // Access sequencing: issue, wait, and park completed/aborted accesses until the entry moves on
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rdata   <= 32'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_byte_en <= 4'b0000;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_fault   <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_addr    <= {io_mau.port_out_m[31:2], 2'b00};
            r_wdata   <= w_st_wdata;
            r_byte_en <= w_be_c;
            r_ren     <= io_mau.dren_m;
            r_wen     <= io_mau.dwen_m;
            if (io_mau.dbus_busy) begin
              r_state   <= BUSY;
              r_cnt     <= CNT_W'(1);
              r_flushed <= io_mau.flush;
            end else if (!io_mau.advance && !io_mau.flush) begin
              r_rdata <= io_mau.dbus_rdata;
              r_state <= HOLD;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (io_mau.flush) r_flushed <= 1'b1;
          if (w_timeout) begin
            if (io_mau.advance || io_mau.flush || r_flushed) begin
              r_state <= IDLE;
            end else begin
              r_fault <= 1'b1;
              r_state <= HOLD;
            end
          end else if (!io_mau.dbus_busy) begin
            if (io_mau.advance || io_mau.flush || r_flushed) begin
              r_state <= IDLE;
            end else begin
              r_rdata <= io_mau.dbus_rdata;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (io_mau.advance || io_mau.flush) begin
            r_state <= IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_mau.dbus_ren     = w_ren;
  assign io_mau.dbus_wen     = w_wen;
  assign io_mau.dbus_addr    = w_req ? ((r_state == IDLE) ? {io_mau.port_out_m[31:2], 2'b00} : r_addr) : 32'd0;
  assign io_mau.dbus_wdata   = w_wen ? ((r_state == IDLE) ? w_st_wdata : r_wdata) : 32'd0;
  assign io_mau.dbus_byte_en = w_req ? ((r_state == IDLE) ? w_be_c : r_byte_en) : 4'b0000;
  assign io_mau.mem_busy     = w_mem_busy;

  // Writeback side is silent for bubbles; a flushed access still draining never writes back
  assign io_mau.reg_wdata = io_mau.valid_m ? w_wb_data : 32'd0;
  assign io_mau.rd_w      = io_mau.valid_m ? io_mau.rd_m : 5'd0;
  assign io_mau.reg_write = io_mau.valid_m & io_mau.reg_write_m & ~w_mal & ~w_fault &
                            ~(io_mau.dren_m & w_mem_busy) & ~w_drain;
  assign io_mau.mal_load  = io_mau.valid_m & io_mau.dren_m & w_mal;
  assign io_mau.mal_store = io_mau.valid_m & io_mau.dwen_m & w_mal;
  assign io_mau.bus_fault = io_mau.valid_m & w_fault;

endmodule

// File: tb/tb_stage3_mem_access_unit.sv
// Randomized bench for stage3_mem_access_unit against a byte-lane arithmetic reference model.
module tb_stage3_mem_access_unit;

  logic CLK = 1'b0;
  logic nRST;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  stage3_mem_access_if bus();

  stage3_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .io_mau (bus)
  );

  // Reference model: byte offsets and sizes with plain arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] lt);
    logic [31:0] v;
    v = rdata >> (32'd8 * (addr % 32'd4));
    case (lt)
      3'b000:  v = ((v % 32'd256) >= 32'd128) ? (v % 32'd256) - 32'd256 : v % 32'd256;
      3'b001:  v = ((v % 32'd65536) >= 32'd32768) ? (v % 32'd65536) - 32'd65536 : v % 32'd65536;
      3'b100:  v = v % 32'd256;
      3'b101:  v = v % 32'd65536;
      default: v = v;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [2:0] lt);
    case (lt % 3'd4)
      3'd0:    return 4'(32'd1 << (addr % 32'd4));
      3'd1:    return ((addr % 32'd4) >= 32'd2) ? 4'hC : 4'h3;
      3'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [2:0] lt);
    case (lt % 3'd4)
      3'd0:    return (rs2 % 32'd256) * 32'h01010101;
      3'd1:    return (rs2 % 32'h10000) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.valid_m = 0; bus.dren_m = 0; bus.dwen_m = 0; bus.reg_write_m = 0;
    bus.rd_m = 0; bus.w_sel_m = 0; bus.load_type_m = 0; bus.port_out_m = 0;
    bus.rs2_data_m = 0; bus.pc4_m = $urandom; bus.imm_U_m = $urandom; bus.csr_rdata = $urandom;
    bus.advance = 1; bus.flush = 0; bus.dbus_rdata = 0; bus.dbus_busy = 0;
  endtask

  task automatic set_mem(input bit is_load, input logic [2:0] lt, input logic [31:0] addr);
    bus.valid_m = 1; bus.dren_m = is_load; bus.dwen_m = !is_load; bus.reg_write_m = is_load;
    bus.rd_m = 5'($urandom_range(1, 31)); bus.w_sel_m = is_load ? 3'd0 : 3'd3;
    bus.load_type_m = lt; bus.port_out_m = addr; bus.rs2_data_m = $urandom; bus.flush = 0;
  endtask

  // One aligned access: n_wait busy cycles, then n_hold cycles parked with advance low
  task automatic run_access(input string tag, input bit is_load, input logic [2:0] lt,
                            input logic [31:0] addr, input int n_wait, input int n_hold,
                            input logic [31:0] rdata);
    logic [70:0] exp_bus;
    logic [70:0] got;
    logic [31:0] exp_val;
    set_mem(is_load, lt, addr);
    exp_val = ref_load(rdata, addr, lt);
    for (int c = 0; c <= n_wait; c++) begin
      bus.dbus_busy  = (c < n_wait);
      bus.dbus_rdata = (c == n_wait) ? rdata : $urandom;
      bus.advance    = (c == n_wait) && (n_hold == 0);
      @(negedge CLK);
      exp_bus = {is_load, !is_load, addr & ~32'd3,
                 is_load ? 32'd0 : ref_wdata(bus.rs2_data_m, lt), ref_be(addr, lt), c < n_wait};
      got = {bus.dbus_ren, bus.dbus_wen, bus.dbus_addr, bus.dbus_wdata, bus.dbus_byte_en, bus.mem_busy};
      n_vec++;
      if (got !== exp_bus) begin
        n_err++; $display("FAIL %s bus c%0d: got %h want %h", tag, c, got, exp_bus);
      end
      n_vec++;
      if (bus.reg_write !== (is_load && c == n_wait)) begin
        n_err++; $display("FAIL %s reg_write c%0d: got %b want %b", tag, c, bus.reg_write, is_load && c == n_wait);
      end
      if (is_load && c == n_wait) begin
        n_vec++;
        if (bus.reg_wdata !== exp_val || bus.rd_w !== bus.rd_m) begin
          n_err++; $display("FAIL %s load_data: got %h rd %0d want %h rd %0d", tag, bus.reg_wdata, bus.rd_w, exp_val, bus.rd_m);
        end
      end
      @(posedge CLK); #1;
    end
    for (int j = 0; j < n_hold; j++) begin
      bus.dbus_busy  = 0;
      bus.dbus_rdata = $urandom;
      bus.advance    = (j == n_hold - 1);
      @(negedge CLK);
      n_vec++;
      if ({bus.dbus_ren, bus.dbus_wen, bus.mem_busy, bus.bus_fault, bus.reg_write} !== {4'b0000, is_load}) begin
        n_err++; $display("FAIL %s hold%0d ctl: got %b want %b", tag, j,
          {bus.dbus_ren, bus.dbus_wen, bus.mem_busy, bus.bus_fault, bus.reg_write}, {4'b0000, is_load});
      end
      if (is_load) begin
        n_vec++;
        if (bus.reg_wdata !== exp_val) begin
          n_err++; $display("FAIL %s hold%0d data: got %h want %h", tag, j, bus.reg_wdata, exp_val);
        end
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
  endtask

  task automatic check_mal(input string tag, input bit is_load, input logic [2:0] lt, input logic [31:0] addr);
    set_mem(is_load, lt, addr);
    bus.dbus_busy = $urandom_range(0, 1);
    bus.advance = 1;
    @(negedge CLK);
    n_vec++;
    if ({bus.dbus_ren, bus.dbus_wen, bus.mem_busy, bus.reg_write, bus.mal_load, bus.mal_store} !==
        {4'b0000, is_load, !is_load}) begin
      n_err++; $display("FAIL %s mal addr %h: got %b want %b", tag, addr,
        {bus.dbus_ren, bus.dbus_wen, bus.mem_busy, bus.reg_write, bus.mal_load, bus.mal_store},
        {4'b0000, is_load, !is_load});
    end
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [111:0] all_out;
    idle_inputs();
    nRST = 0;
    set_mem(1'b1, 3'b010, 32'h40);
    #12;
    n_vec++;
    if (bus.dbus_ren !== 1'b0) begin
      n_err++; $display("FAIL reset_req: got %b want 0", bus.dbus_ren);
    end
    @(posedge CLK); #1;
    nRST = 1;
    bus.valid_m = 0; bus.w_sel_m = 3'd1;
    @(negedge CLK);
    all_out = {bus.dbus_ren, bus.dbus_wen, bus.dbus_addr, bus.dbus_wdata, bus.dbus_byte_en, bus.mem_busy,
               bus.reg_wdata, bus.rd_w, bus.reg_write, bus.mal_load, bus.mal_store, bus.bus_fault};
    n_vec++;
    if (all_out !== 112'd0) begin
      n_err++; $display("FAIL bubble_outputs: got %h want 0", all_out);
    end
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic test_directed();
    run_access("lw_wait2", 1'b1, 3'b010, 32'h100, 2, 0, 32'hDEADBEEF);
    run_access("lb_sext",  1'b1, 3'b000, 32'h103, 0, 0, 32'h80123456);
    run_access("lbu_zext", 1'b1, 3'b100, 32'h103, 1, 0, 32'h80123456);
    run_access("lhu",      1'b1, 3'b101, 32'h102, 0, 0, 32'hBEEF0000);
    run_access("sh_zw",    1'b0, 3'b001, 32'h102, 0, 0, 32'h0);
    run_access("lw_hold3", 1'b1, 3'b010, 32'h204, 1, 3, 32'hCAFEF00D);
    check_mal("lw_mis", 1'b1, 3'b010, 32'h101);
    check_mal("sw_mis", 1'b0, 3'b010, 32'h102);
  endtask

  task automatic test_random_access();
    logic [2:0] ld_types [5];
    logic [2:0] lt;
    logic [31:0] a;
    bit ld;
    ld_types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    repeat (40) begin
      ld = $urandom_range(0, 1);
      lt = ld ? ld_types[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom;
      if (lt[1:0] == 2'b01) a[0] = 1'b0;
      if (lt[1:0] == 2'b10) a[1:0] = 2'b00;
      run_access("rand", ld, lt, a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0] lt;
    logic [31:0] a;
    repeat (10) begin
      lt = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
      a = $urandom;
      if (lt == 3'b001) a[0] = 1'b1;
      else a[1:0] = 2'($urandom_range(1, 3));
      check_mal("rand_mis", 1'($urandom_range(0, 1)), lt, a);
    end
  endtask

  task automatic test_wb_mux();
    logic [31:0] exp;
    repeat (16) begin
      bus.valid_m = 1; bus.dren_m = 0; bus.dwen_m = 0; bus.reg_write_m = $urandom_range(0, 1);
      bus.rd_m = 5'($urandom); bus.w_sel_m = 3'($urandom_range(1, 7)); bus.load_type_m = 3'($urandom);
      bus.port_out_m = $urandom; bus.pc4_m = $urandom; bus.imm_U_m = $urandom; bus.csr_rdata = $urandom;
      bus.advance = 1;
      case (bus.w_sel_m)
        3'd1: exp = bus.pc4_m;
        3'd2: exp = bus.imm_U_m;
        3'd3: exp = bus.port_out_m;
        3'd4: exp = bus.csr_rdata;
        default: exp = 32'd0;
      endcase
      @(negedge CLK);
      n_vec++;
      if ({bus.reg_wdata, bus.rd_w, bus.reg_write, bus.dbus_ren, bus.dbus_wen, bus.mal_load, bus.mal_store} !==
          {exp, bus.rd_m, bus.reg_write_m, 4'b0000}) begin
        n_err++; $display("FAIL wb_mux sel %0d: got %h rd %0d we %b want %h rd %0d we %b", bus.w_sel_m,
          bus.reg_wdata, bus.rd_w, bus.reg_write, exp, bus.rd_m, bus.reg_write_m);
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
  endtask

  // Flushed load keeps the bus request alive until the bus finishes, without writing back
  task automatic test_flush_drain();
    set_mem(1'b1, 3'b010, 32'h300);
    bus.dbus_busy = 1; bus.flush = 1; bus.advance = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      n_vec++;
      if ({bus.dbus_ren, bus.dbus_addr, bus.mem_busy, bus.reg_write} !== {c < 3, (c < 3) ? 32'h300 : 32'h0, c < 2, 1'b0}) begin
        n_err++; $display("FAIL flush_drain c%0d: got ren %b addr %h mb %b we %b", c,
          bus.dbus_ren, bus.dbus_addr, bus.mem_busy, bus.reg_write);
      end
      @(posedge CLK); #1;
      bus.valid_m = 0; bus.dren_m = 0; bus.flush = 0; bus.port_out_m = $urandom;
      bus.dbus_busy = (c == 0);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    set_mem(1'b1, 3'b010, 32'h400);
    bus.dbus_busy = 1; bus.advance = 0;
    for (int c = 0; c < 7; c++) begin
      bus.advance = (c == 5);
      if (c == 6) begin bus.valid_m = 0; bus.dbus_busy = 0; end
      @(negedge CLK);
      n_vec++;
      if ({bus.dbus_ren, bus.mem_busy, bus.bus_fault, bus.reg_write} !==
          {c < 4, c < 4, c == 4 || c == 5, 1'b0}) begin
        n_err++; $display("FAIL timeout c%0d: got ren %b mb %b fault %b we %b want %b %b %b 0", c,
          bus.dbus_ren, bus.mem_busy, bus.bus_fault, bus.reg_write, c < 4, c < 4, c == 4 || c == 5);
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    set_mem(1'b1, 3'b010, 32'h500);
    bus.dbus_busy = 1; bus.advance = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_vec++;
    if (bus.dbus_ren !== 1'b1) begin
      n_err++; $display("FAIL rst_mid pre: got ren %b want 1", bus.dbus_ren);
    end
    nRST = 0;
    #1;
    n_vec++;
    if ({bus.dbus_ren, bus.mem_busy} !== 2'b00) begin
      n_err++; $display("FAIL rst_mid drop: got %b want 00", {bus.dbus_ren, bus.mem_busy});
    end
    @(posedge CLK); #1;
    nRST = 1;
    run_access("post_rst", 1'b1, 3'b001, 32'h502, 0, 0, 32'h8001_7F00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random_access();
    test_misaligned();
    test_wb_mux();
    test_flush_drain();
    test_timeout();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
